ifu: RTL and testbench
======================

# ifu

Instruction fetch unit for the npc single-issue RV32 core; it is the producer end of the instruction interface that feeds the decode stage. It holds the PC and issues one word read at a time to instruction memory over a valid/ready request plus valid-only response. It presents each fetched word with its PC to decode under a valid/ready handshake. It accepts redirects (jal/jalr/branch targets) from execute, discarding any in-flight or held instruction from the old path.

## Interface
- RESET_PC, 32'h8000_0000, PC value loaded on reset
- clk  in  1  core clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- imem_req_valid  out  1  read request valid
- imem_req_ready  in  1  memory accepts request this cycle
- imem_req_addr  out  32  word address of the request (= pc, bits [1:0] always 0)
- imem_rsp_valid  in  1  read data valid (no ready; memory never stalls the response)
- imem_rsp_data  in  32  read data
- inst_valid  out  1  inst/inst_pc hold a valid instruction for decode
- inst_ready  in  1  decode consumes the instruction this cycle
- inst  out  32  instruction word
- inst_pc  out  32  PC of inst
- redirect_valid  in  1  execute requests fetch from redirect_pc
- redirect_pc  in  32  new PC; bits [1:0] ignored and stored as 0

## Operation
- FSM states: REQ, WAIT, HOLD, DROP. Request handshake = imem_req_valid & imem_req_ready; decode handshake = inst_valid & inst_ready.
- imem_req_valid = (state==REQ) & !rst; imem_req_addr = pc. inst_valid = (state==HOLD) & !rst.
- REQ: redirect & handshake -> DROP, pc<=redirect_pc. Redirect, no handshake -> REQ, pc<=redirect_pc (address changes before acceptance is allowed). Handshake, no redirect -> WAIT.
- WAIT: rsp_valid, no redirect -> HOLD, inst<=rsp_data, inst_pc<=pc. Redirect, no rsp -> DROP, pc<=redirect_pc. Redirect & rsp -> REQ, pc<=redirect_pc, data discarded.
- HOLD: redirect (priority over inst_ready) -> REQ, pc<=redirect_pc; the presented instruction is withdrawn and decode must treat that cycle's handshake as void. inst_ready, no redirect -> REQ, pc<=pc+4 (32-bit wrap, 32'hFFFF_FFFC+4 = 0).
- DROP: awaits the single stale response. rsp_valid -> REQ (data discarded); a redirect in the same or any DROP cycle updates pc, and DROP still exits only on rsp_valid.
- rsp_valid in REQ or HOLD is a protocol violation; ignored.
- inst/inst_pc change only on WAIT->HOLD; stable throughout HOLD.

## Timing
- Reset: state<=REQ, pc<=RESET_PC, inst<=0, inst_pc<=0; while rst is high imem_req_valid=0, inst_valid=0. First request visible the cycle after rst falls.
- Reset mid-operation returns to REQ at the next edge; an outstanding memory response arriving afterwards lands in REQ and is ignored, so the memory must be reset alongside.
- Memory responds no earlier than the cycle after request acceptance; at most one request outstanding.
- Best case: request accepted cycle N, response N+1, inst_valid N+2, consumed N+2, next request N+3: one instruction per 3 cycles.
- Redirect to new request: 1 cycle from REQ/WAIT(with rsp)/HOLD; from DROP/WAIT(no rsp), 1 cycle after the stale response.

## Structure
- Shared package npc_pkg: RESET_PC default, ifu state enum (REQ, WAIT, HOLD, DROP), XLEN=32.
- One sub-module, ifu_pc: PC register with next-PC mux (hold / +4 / redirect, bits [1:0] cleared); FSM and instruction buffer stay in ifu.

## Test plan
- Reset then zero-wait memory returning 32'h00000013 and inst_ready=1: requests at 8000_0000, 8000_0004, 8000_0008; inst_valid every 3rd cycle with matching inst_pc.
- Decode stall: inst_ready=0 for 5 cycles in HOLD -> inst/inst_pc stable, no new request; release -> next request at pc+4.
- Redirect in WAIT to 32'h8000_0100, response 2 cycles later -> DROP, data discarded, next request addr 8000_0100, no inst_valid from old path.
- Redirect in HOLD with inst_ready=1 same cycle, redirect_pc=32'h8000_0203 -> next request addr 8000_0200, old pc+4 never requested.
- Redirect coinciding with request acceptance -> DROP; stale response consumed; then request at redirect target.
- rst asserted in HOLD -> next cycle inst_valid=0, inst=0, request at RESET_PC after rst falls; stray rsp_valid in REQ ignored.

Source files
------------

// File: rtl/npc_pkg.sv
// Shared definitions for the npc core front end.
// Holds the data width, reset PC and fetch FSM state encoding.
package npc_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC = 32'h8000_0000;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2,
        ST_DROP = 2'd3
    } ifu_state_e;

endpackage

// File: rtl/ifu_if.sv
// Fetch-side bus bundle: imem request/response, decode handoff, redirect.
// master = fetch unit; slave = memory/decode/execute environment.
interface ifu_if;
    import npc_pkg::*;

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;

    logic            inst_valid;
    logic            inst_ready;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] inst_pc;

    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data,
        output inst_valid,
        output inst,
        output inst_pc,
        input  inst_ready,
        input  redirect_valid,
        input  redirect_pc
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data,
        input  inst_valid,
        input  inst,
        input  inst_pc,
        output inst_ready,
        output redirect_valid,
        output redirect_pc
    );

endinterface

// File: rtl/ifu_pc.sv
// Program counter register with hold / +4 / redirect next-PC selection.
// Ports: i_clk, i_rst, i_inc, i_redir, i_redir_pc in; o_pc out.
module ifu_pc
    import npc_pkg::*;
#(
    parameter logic [XLEN-1:0] P_RESET_PC = RESET_PC
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_inc,
    input  logic            i_redir,
    input  logic [XLEN-1:0] i_redir_pc,
    output logic [XLEN-1:0] o_pc
);

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_redir_al;

    // Targets are word aligned; low bits are dropped.
    assign w_redir_al = i_redir_pc & ~32'd3;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pc <= P_RESET_PC;
        end else if (i_redir) begin
            r_pc <= w_redir_al;
        end else if (i_inc) begin
            r_pc <= r_pc + 32'd4;
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: one outstanding imem read, single-entry buffer.
// Ports: i_clk, i_rst, bus (ifu_if.master: imem, decode, redirect).
module ifu
    import npc_pkg::*;
#(
    parameter logic [XLEN-1:0] P_RESET_PC = RESET_PC
) (
    input  logic   i_clk,
    input  logic   i_rst,
    ifu_if.master  bus
);

    ifu_state_e      r_state;
    ifu_state_e      w_state_nxt;
    logic [XLEN-1:0] r_inst;
    logic [XLEN-1:0] r_inst_pc;
    logic [XLEN-1:0] w_pc;
    logic            w_req_hs;
    logic            w_redir;
    logic            w_inc;
    logic            w_load;

    assign w_redir  = bus.redirect_valid;
    assign w_req_hs = bus.imem_req_valid & bus.imem_req_ready;

    ifu_pc #(
        .P_RESET_PC (P_RESET_PC)
    ) u_pc (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_inc      (w_inc),
        .i_redir    (w_redir),
        .i_redir_pc (bus.redirect_pc),
        .o_pc       (w_pc)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_inc       = 1'b0;
        w_load      = 1'b0;
        unique case (r_state)
            ST_REQ: begin
                // An accepted request to the old path leaves a stale
                // response in flight that must be swallowed.
                if (w_redir) begin
                    w_state_nxt = w_req_hs ? ST_DROP : ST_REQ;
                end else if (w_req_hs) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.imem_rsp_valid) begin
                    if (w_redir) begin
                        w_state_nxt = ST_REQ;
                    end else begin
                        w_state_nxt = ST_HOLD;
                        w_load      = 1'b1;
                    end
                end else if (w_redir) begin
                    w_state_nxt = ST_DROP;
                end
            end
            ST_HOLD: begin
                // Redirect wins; a same-cycle decode handshake is void.
                if (w_redir) begin
                    w_state_nxt = ST_REQ;
                end else if (bus.inst_ready) begin
                    w_state_nxt = ST_REQ;
                    w_inc       = 1'b1;
                end
            end
            ST_DROP: begin
                if (bus.imem_rsp_valid) begin
                    w_state_nxt = ST_REQ;
                end
            end
            default: begin
                w_state_nxt = ST_REQ;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= ST_REQ;
            r_inst    <= '0;
            r_inst_pc <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_inst    <= bus.imem_rsp_data;
                r_inst_pc <= w_pc;
            end
        end
    end

    assign bus.imem_req_valid = (r_state == ST_REQ) & ~i_rst;
    assign bus.imem_req_addr  = w_pc;
    assign bus.inst_valid     = (r_state == ST_HOLD) & ~i_rst;
    assign bus.inst           = r_inst;
    assign bus.inst_pc        = r_inst_pc;

endmodule

// File: tb/tb_ifu.sv
// Directed bench for ifu: per-cycle vector table plus a throughput run.
// Inputs change at negedge; outputs are sampled 1ns later.
module tb_ifu;

    logic clk;
    logic rst;

    ifu_if u_bus ();

    ifu u_dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (u_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        rv;
        logic [31:0] rd;
        logic        ir;
        logic        xv;
        logic [31:0] xpc;
        logic        e_rv;
        logic [31:0] e_addr;
        logic        e_iv;
        logic [31:0] e_inst;
        logic [31:0] e_ipc;
    } vec_t;

    vec_t vecs[$];
    int   n_pass;
    int   n_total;

    localparam logic [31:0] B   = 32'h8000_0000;
    localparam logic [31:0] D1  = 32'h0000_0013;
    localparam logic [31:0] D2  = 32'h0010_0093;
    localparam logic [31:0] D3  = 32'h0020_0113;
    localparam logic [31:0] D4  = 32'h0030_8193;
    localparam logic [31:0] D5  = 32'h0040_0213;
    localparam logic [31:0] D6  = 32'h0000_0073;
    localparam logic [31:0] BAD = 32'hDEAD_BEEF;

    function automatic vec_t mk(
        input logic rst_i, input logic rdy, input logic rv,
        input logic [31:0] rd, input logic ir, input logic xv,
        input logic [31:0] xpc, input logic e_rv,
        input logic [31:0] e_addr, input logic e_iv,
        input logic [31:0] e_inst, input logic [31:0] e_ipc);
        vec_t v;
        v.rst = rst_i; v.rdy = rdy; v.rv = rv; v.rd = rd;
        v.ir = ir; v.xv = xv; v.xpc = xpc;
        v.e_rv = e_rv; v.e_addr = e_addr; v.e_iv = e_iv;
        v.e_inst = e_inst; v.e_ipc = e_ipc;
        return v;
    endfunction

    task automatic drive(input logic r, input logic rdy, input logic rv,
                         input logic [31:0] rd, input logic ir,
                         input logic xv, input logic [31:0] xpc);
        rst                  = r;
        u_bus.imem_req_ready = rdy;
        u_bus.imem_rsp_valid = rv;
        u_bus.imem_rsp_data  = rd;
        u_bus.inst_ready     = ir;
        u_bus.redirect_valid = xv;
        u_bus.redirect_pc    = xpc;
    endtask

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    initial begin
        logic        prev_hs;
        logic [31:0] exp_pc;
        int          n_inst;

        n_pass  = 0;
        n_total = 0;

        //              rst rdy rv rd  ir xv xpc     | rv addr iv inst ipc
        vecs.push_back(mk(1, 0, 0, 0,  0, 0, 0,      0, B,       0, 0,  0));
        vecs.push_back(mk(0, 1, 0, 0,  0, 0, 0,      1, B,       0, 0,  0));
        vecs.push_back(mk(0, 1, 1, D1, 0, 0, 0,      0, B,       0, 0,  0));
        vecs.push_back(mk(0, 0, 0, 0,  1, 0, 0,      0, B,       1, D1, B));
        vecs.push_back(mk(0, 1, 0, 0,  0, 0, 0,      1, B+4,     0, D1, B));
        vecs.push_back(mk(0, 0, 1, D2, 0, 0, 0,      0, B+4,     0, D1, B));
        vecs.push_back(mk(0, 0, 0, 0,  1, 0, 0,      0, B+4,     1, D2, B+4));
        vecs.push_back(mk(0, 1, 0, 0,  0, 0, 0,      1, B+8,     0, D2, B+4));
        vecs.push_back(mk(0, 0, 1, D3, 0, 0, 0,      0, B+8,     0, D2, B+4));
        // decode stall in HOLD, with one stray response
        vecs.push_back(mk(0, 1, 0, 0,  0, 0, 0,      0, B+8,     1, D3, B+8));
        vecs.push_back(mk(0, 1, 0, 0,  0, 0, 0,      0, B+8,     1, D3, B+8));
        vecs.push_back(mk(0, 1, 1, BAD,0, 0, 0,      0, B+8,     1, D3, B+8));
        vecs.push_back(mk(0, 1, 0, 0,  0, 0, 0,      0, B+8,     1, D3, B+8));
        vecs.push_back(mk(0, 1, 0, 0,  0, 0, 0,      0, B+8,     1, D3, B+8));
        vecs.push_back(mk(0, 0, 0, 0,  1, 0, 0,      0, B+8,     1, D3, B+8));
        vecs.push_back(mk(0, 0, 0, 0,  0, 0, 0,      1, B+12,    0, D3, B+8));
        vecs.push_back(mk(0, 1, 0, 0,  0, 0, 0,      1, B+12,    0, D3, B+8));
        // redirect in WAIT, stale response two cycles later
        vecs.push_back(mk(0, 0, 0, 0,  0, 1, B+'h100,0, B+12,    0, D3, B+8));
        vecs.push_back(mk(0, 0, 0, 0,  0, 0, 0,      0, B+'h100, 0, D3, B+8));
        vecs.push_back(mk(0, 0, 1, BAD,0, 0, 0,      0, B+'h100, 0, D3, B+8));
        vecs.push_back(mk(0, 1, 0, 0,  0, 0, 0,      1, B+'h100, 0, D3, B+8));
        vecs.push_back(mk(0, 0, 1, D4, 0, 0, 0,      0, B+'h100, 0, D3, B+8));
        // redirect in HOLD with inst_ready, unaligned target
        vecs.push_back(mk(0, 0, 0, 0,  1, 1, B+'h203,0, B+'h100, 1, D4, B+'h100));
        // redirect in REQ without acceptance
        vecs.push_back(mk(0, 0, 0, 0,  0, 1, B+'h300,1, B+'h200, 0, D4, B+'h100));
        // redirect coinciding with acceptance, then redirect in DROP
        vecs.push_back(mk(0, 1, 0, 0,  0, 1, B+'h400,1, B+'h300, 0, D4, B+'h100));
        vecs.push_back(mk(0, 1, 0, 0,  0, 1, B+'h500,0, B+'h400, 0, D4, B+'h100));
        vecs.push_back(mk(0, 1, 1, BAD,0, 0, 0,      0, B+'h500, 0, D4, B+'h100));
        vecs.push_back(mk(0, 1, 0, 0,  0, 0, 0,      1, B+'h500, 0, D4, B+'h100));
        // redirect in WAIT with response: data dropped, straight to REQ
        vecs.push_back(mk(0, 0, 1, BAD,0, 1, B+'h600,0, B+'h500, 0, D4, B+'h100));
        vecs.push_back(mk(0, 1, 0, 0,  0, 0, 0,      1, B+'h600, 0, D4, B+'h100));
        vecs.push_back(mk(0, 0, 1, D5, 0, 0, 0,      0, B+'h600, 0, D4, B+'h100));
        vecs.push_back(mk(0, 0, 0, 0,  0, 0, 0,      0, B+'h600, 1, D5, B+'h600));
        // reset while holding
        vecs.push_back(mk(1, 0, 0, 0,  0, 0, 0,      0, B+'h600, 0, D5, B+'h600));
        vecs.push_back(mk(0, 0, 1, BAD,0, 0, 0,      1, B,       0, 0,  0));
        // PC wrap at top of address space
        vecs.push_back(mk(0, 0, 0, 0,  0, 1, 32'hFFFF_FFFF,
                                                     1, B,       0, 0,  0));
        vecs.push_back(mk(0, 1, 0, 0,  0, 0, 0,      1, 32'hFFFF_FFFC, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, D6, 0, 0, 0,      0, 32'hFFFF_FFFC, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0,  1, 0, 0,      0, 32'hFFFF_FFFC, 1, D6,
                          32'hFFFF_FFFC));
        vecs.push_back(mk(0, 0, 0, 0,  0, 0, 0,      1, 32'h0, 0, D6,
                          32'hFFFF_FFFC));

        drive(1, 0, 0, 0, 0, 0, 0);
        @(posedge clk);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].rdy, vecs[i].rv, vecs[i].rd,
                  vecs[i].ir, vecs[i].xv, vecs[i].xpc);
            #1;
            n_total++;
            if (u_bus.imem_req_valid === vecs[i].e_rv &&
                u_bus.imem_req_addr  === vecs[i].e_addr &&
                u_bus.inst_valid     === vecs[i].e_iv &&
                u_bus.inst           === vecs[i].e_inst &&
                u_bus.inst_pc        === vecs[i].e_ipc) begin
                n_pass++;
            end else begin
                $display("FAIL vec%0d: got rv=%b addr=%h iv=%b inst=%h ipc=%h expected rv=%b addr=%h iv=%b inst=%h ipc=%h",
                         i, u_bus.imem_req_valid, u_bus.imem_req_addr,
                         u_bus.inst_valid, u_bus.inst, u_bus.inst_pc,
                         vecs[i].e_rv, vecs[i].e_addr, vecs[i].e_iv,
                         vecs[i].e_inst, vecs[i].e_ipc);
            end
        end

        // Throughput run: zero-wait memory answering the cycle after
        // acceptance, decode always ready -> 3 instructions in 9 cycles.
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        prev_hs = 1'b0;
        exp_pc  = B;
        n_inst  = 0;
        for (int c = 0; c < 9; c++) begin
            drive(0, 1, prev_hs, D1, 1, 0, 0);
            #1;
            if (u_bus.inst_valid) begin
                check("tput_pc", u_bus.inst_pc, exp_pc);
                check("tput_inst", u_bus.inst, D1);
                exp_pc += 4;
                n_inst++;
            end
            prev_hs = u_bus.imem_req_valid & u_bus.imem_req_ready;
            @(negedge clk);
        end
        check("tput_count", 32'(n_inst), 32'd3);
        check("tput_next_addr", u_bus.imem_req_addr, B + 32'd12);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
